// File: rtl/nios2_cpu_mul_pkg.sv
// Shared mode encodings and mode decode helpers for the Nios II multiplier pipeline.
package nios2_cpu_mul_pkg;

  localparam logic [1:0] MUL_MODE_MUL = 2'b00;
  localparam logic [1:0] MUL_MODE_XUU = 2'b01;
  localparam logic [1:0] MUL_MODE_XSU = 2'b10;
  localparam logic [1:0] MUL_MODE_XSS = 2'b11;

  function automatic logic mode_a_signed(input logic [1:0] mode);
    return (mode == MUL_MODE_XSU) || (mode == MUL_MODE_XSS);
  endfunction

  function automatic logic mode_b_signed(input logic [1:0] mode);
    return mode == MUL_MODE_XSS;
  endfunction

  function automatic logic mode_hi(input logic [1:0] mode);
    return mode != MUL_MODE_MUL;
  endfunction

endpackage

// File: rtl/nios2_cpu_mul_pp.sv
// One registered signed (WA+1)x(WB+1) partial-product multiplier; kept as plain RTL so it maps onto a DSP block.
module nios2_cpu_mul_pp #(
  parameter int WA = 16,
  parameter int WB = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic signed [WA:0]       a,
  input  logic signed [WB:0]       b,
  output logic signed [WA+WB+1:0]  p
);

  localparam int PW = WA + WB + 2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
    end else if (en) begin
      p <= PW'(a) * PW'(b);
    end
  end

endmodule

// File: rtl/nios2_cpu_mul_pipe.sv
// Pipelined Nios II integer multiplier: MUL/MULXUU/MULXSU/MULXSS with stall, flush and valid tracking.
module nios2_cpu_mul_pipe
  import nios2_cpu_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  output logic [1:0]        out_mode,
  output logic [DATA_W-1:0] out_result
);

  localparam int H  = DATA_W / 2;
  localparam int PW = 2 * H + 2;
  localparam int SW = 2 * DATA_W + 2;

  // Stage 0: extend each operand to DATA_W+1 bits and split into halves
  logic signed [DATA_W:0] a_ext_p0, b_ext_p0;
  logic signed [H:0]      a_lo_p0, a_hi_p0, b_lo_p0, b_hi_p0;

  assign a_ext_p0 = {mode_a_signed(in_mode) & in_src1[DATA_W-1], in_src1};
  assign b_ext_p0 = {mode_b_signed(in_mode) & in_src2[DATA_W-1], in_src2};
  assign a_lo_p0  = {1'b0, in_src1[H-1:0]};
  assign b_lo_p0  = {1'b0, in_src2[H-1:0]};
  assign a_hi_p0  = a_ext_p0[DATA_W:H];
  assign b_hi_p0  = b_ext_p0[DATA_W:H];

  // Stage 1: registered partial products plus control
  logic signed [PW-1:0] pp_ll_p1, pp_lh_p1, pp_hl_p1, pp_hh_p1;
  logic                 vld_p1;
  logic [1:0]           mode_p1;

  nios2_cpu_mul_pp #(.WA(H), .WB(H)) u_pp_ll (
    .clk(clk), .reset_n(reset_n), .en(en), .a(a_lo_p0), .b(b_lo_p0), .p(pp_ll_p1)
  );
  nios2_cpu_mul_pp #(.WA(H), .WB(H)) u_pp_lh (
    .clk(clk), .reset_n(reset_n), .en(en), .a(a_lo_p0), .b(b_hi_p0), .p(pp_lh_p1)
  );
  nios2_cpu_mul_pp #(.WA(H), .WB(H)) u_pp_hl (
    .clk(clk), .reset_n(reset_n), .en(en), .a(a_hi_p0), .b(b_lo_p0), .p(pp_hl_p1)
  );
  nios2_cpu_mul_pp #(.WA(H), .WB(H)) u_pp_hh (
    .clk(clk), .reset_n(reset_n), .en(en), .a(a_hi_p0), .b(b_hi_p0), .p(pp_hh_p1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      mode_p1 <= '0;
    end else begin
      if (en) begin
        vld_p1  <= in_valid;
        mode_p1 <= in_mode;
      end
      if (flush) vld_p1 <= 1'b0;
    end
  end

  // Stage 2: sum the partial products and select the requested half
  logic signed [SW-1:0]     sum_p1;
  logic [2*DATA_W-1:0]      prod_p1;
  logic [DATA_W-1:0]        res_p1;
  logic                     unused_sum_hi;

  assign sum_p1 = SW'(pp_ll_p1) + (SW'(pp_lh_p1) <<< H) + (SW'(pp_hl_p1) <<< H)
                + (SW'(pp_hh_p1) <<< (2 * H));
  assign prod_p1       = sum_p1[2*DATA_W-1:0];
  assign unused_sum_hi = ^sum_p1[SW-1:2*DATA_W];
  assign res_p1        = mode_hi(mode_p1) ? prod_p1[2*DATA_W-1:DATA_W] : prod_p1[DATA_W-1:0];

  // Stages 2..LAT: result register followed by pure delay for retiming slack
  logic              vld_pipe  [2:LAT];
  logic [1:0]        mode_pipe [2:LAT];
  logic [DATA_W-1:0] res_pipe  [2:LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 2; k <= LAT; k++) begin
        vld_pipe[k]  <= 1'b0;
        mode_pipe[k] <= '0;
        res_pipe[k]  <= '0;
      end
    end else begin
      if (en) begin
        vld_pipe[2]  <= vld_p1;
        mode_pipe[2] <= mode_p1;
        res_pipe[2]  <= res_p1;
        for (int k = 3; k <= LAT; k++) begin
          vld_pipe[k]  <= vld_pipe[k-1];
          mode_pipe[k] <= mode_pipe[k-1];
          res_pipe[k]  <= res_pipe[k-1];
        end
      end
      if (flush) begin
        for (int k = 2; k <= LAT; k++) vld_pipe[k] <= 1'b0;
      end
    end
  end

  assign out_valid  = vld_pipe[LAT];
  assign out_mode   = mode_pipe[LAT];
  assign out_result = res_pipe[LAT];

endmodule

// File: tb/tb_nios2_cpu_mul_pipe.sv
// Bench for nios2_cpu_mul_pipe: one 32-bit/LAT=2 instance and one 16-bit/LAT=4 instance on a shared clock.
module tb_nios2_cpu_mul_pipe;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        en32, flush32, v32, ov32;
  logic [1:0]  m32, om32;
  logic [31:0] a32, b32, or32;

  logic        en16, flush16, v16, ov16;
  logic [1:0]  m16, om16;
  logic [15:0] a16, b16, or16;

  int total = 0;
  int bad   = 0;

  nios2_cpu_mul_pipe #(.DATA_W(32), .LAT(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .en(en32), .flush(flush32), .in_valid(v32),
    .in_mode(m32), .in_src1(a32), .in_src2(b32),
    .out_valid(ov32), .out_mode(om32), .out_result(or32)
  );

  nios2_cpu_mul_pipe #(.DATA_W(16), .LAT(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .en(en16), .flush(flush16), .in_valid(v16),
    .in_mode(m16), .in_src1(a16), .in_src2(b16),
    .out_valid(ov16), .out_mode(om16), .out_result(or16)
  );

  // Reference: full-precision product of the extended operands, then half select.
  function automatic logic [31:0] ref_res(input int w, input logic [1:0] m,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [127:0] av, bv, p;
    logic [127:0] pu, mask;
    av = {96'b0, a};
    bv = {96'b0, b};
    if (m[1] && a[w-1]) av = av - (128'sd1 <<< w);
    if (m == 2'b11 && b[w-1]) bv = bv - (128'sd1 <<< w);
    p = av * bv;
    pu = p;
    mask = (128'd1 << w) - 128'd1;
    pu = (m == 2'b00) ? (pu & mask) : ((pu >> w) & mask);
    return pu[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_8000;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en32 = 1'b1; flush32 = 1'b0; v32 = 1'b0; m32 = 2'b00; a32 = '0; b32 = '0;
    en16 = 1'b1; flush16 = 1'b0; v16 = 1'b0; m16 = 2'b00; a16 = '0; b16 = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    v32 = 1'b1; m32 = 2'b01; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
    v16 = 1'b1; m16 = 2'b01; a16 = 16'hFFFF; b16 = 16'hFFFF;
    step(); step(); step();
    total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL reset_valid32 got=%b want=0", ov32); end
    total++; if (om32 !== 2'b00) begin bad++; $display("FAIL reset_mode32 got=%b want=00", om32); end
    total++; if (or32 !== 32'h0) begin bad++; $display("FAIL reset_result32 got=%h want=0", or32); end
    total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL reset_valid16 got=%b want=0", ov16); end
    total++; if (or16 !== 16'h0) begin bad++; $display("FAIL reset_result16 got=%h want=0", or16); end
    idle_inputs();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_directed32();
    logic [1:0]  tm [8];
    logic [31:0] ta [8], tb [8], te [8];
    tm = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10};
    ta = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    tb = ta;
    te = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000,
           32'hFFFF_FFFF, 32'h0000_0001, 32'h4000_0000, 32'hC000_0000};
    for (int i = 0; i < 8; i++) begin
      v32 = 1'b1; m32 = tm[i]; a32 = ta[i]; b32 = tb[i];
      step();
      v32 = 1'b0;
      total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL dir32_early[%0d] valid got=%b want=0", i, ov32); end
      step();
      total++;
      if (ov32 !== 1'b1 || or32 !== te[i] || om32 !== tm[i]) begin
        bad++;
        $display("FAIL dir32[%0d] got v=%b r=%h m=%b want v=1 r=%h m=%b", i, ov32, or32, om32, te[i], tm[i]);
      end
      step();
    end
  endtask

  task automatic test_directed16();
    logic [1:0]  tm [6];
    logic [15:0] ta [6], te [6];
    tm = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00};
    ta = '{16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    te = '{16'h0000, 16'h0001, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h0001};
    for (int i = 0; i < 6; i++) begin
      v16 = 1'b1; m16 = tm[i]; a16 = ta[i]; b16 = ta[i];
      step();
      v16 = 1'b0;
      for (int c = 1; c < 4; c++) begin
        total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL dir16_early[%0d] cyc=%0d valid got=%b want=0", i, c, ov16); end
        step();
      end
      total++;
      if (ov16 !== 1'b1 || or16 !== te[i] || om16 !== tm[i]) begin
        bad++;
        $display("FAIL dir16[%0d] got v=%b r=%h m=%b want v=1 r=%h m=%b", i, ov16, or16, om16, te[i], tm[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [1:0]  m [4];
    logic [31:0] a [4], b [4], e [4];
    for (int i = 0; i < 4; i++) begin
      m[i] = 2'($urandom); a[i] = pick_operand(); b[i] = pick_operand();
      e[i] = ref_res(32, m[i], a[i], b[i]);
    end
    en32 = 1'b1;
    v32 = 1'b1; m32 = m[0]; a32 = a[0]; b32 = b[0];
    step();
    m32 = m[1]; a32 = a[1]; b32 = b[1];
    step();
    total++; if (ov32 !== 1'b1 || or32 !== e[0]) begin bad++; $display("FAIL b2b_op0 got v=%b r=%h want v=1 r=%h", ov32, or32, e[0]); end
    en32 = 1'b0;
    m32 = m[2]; a32 = a[2]; b32 = b[2];
    for (int s = 0; s < 3; s++) begin
      step();
      total++;
      if (ov32 !== 1'b1 || or32 !== e[0] || om32 !== m[0]) begin
        bad++;
        $display("FAIL stall_hold[%0d] got v=%b r=%h m=%b want v=1 r=%h m=%b", s, ov32, or32, om32, e[0], m[0]);
      end
    end
    en32 = 1'b1;
    step();
    total++; if (ov32 !== 1'b1 || or32 !== e[1]) begin bad++; $display("FAIL b2b_op1 got v=%b r=%h want v=1 r=%h", ov32, or32, e[1]); end
    m32 = m[3]; a32 = a[3]; b32 = b[3];
    step();
    v32 = 1'b0;
    total++; if (ov32 !== 1'b1 || or32 !== e[2]) begin bad++; $display("FAIL b2b_op2 got v=%b r=%h want v=1 r=%h", ov32, or32, e[2]); end
    step();
    total++; if (ov32 !== 1'b1 || or32 !== e[3] || om32 !== m[3]) begin bad++; $display("FAIL b2b_op3 got v=%b r=%h want v=1 r=%h", ov32, or32, e[3]); end
    step();
    total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL b2b_tail valid got=%b want=0", ov32); end
  endtask

  task automatic test_flush32();
    v32 = 1'b1; m32 = 2'b01; a32 = 32'hFFFF_FFFF; b32 = 32'h1234_5678;
    step();
    flush32 = 1'b1; m32 = 2'b11; a32 = 32'h8000_0000; b32 = 32'h8000_0000;
    step();
    flush32 = 1'b0; v32 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL flush32[%0d] valid got=%b want=0", s, ov32); end
      step();
    end
    v32 = 1'b1; m32 = 2'b10; a32 = 32'h8000_0000; b32 = 32'h8000_0000;
    step();
    v32 = 1'b0;
    step();
    total++; if (ov32 !== 1'b1 || or32 !== 32'hC000_0000) begin bad++; $display("FAIL flush32_after got v=%b r=%h want v=1 r=c0000000", ov32, or32); end
    step();
  endtask

  task automatic test_flush16();
    logic [15:0] ea, eb;
    ea = 16'($urandom); eb = 16'($urandom);
    v16 = 1'b1; m16 = 2'b01; a16 = 16'h1234; b16 = 16'hABCD;
    step();
    m16 = 2'b11; a16 = 16'h8000;
    step();
    flush16 = 1'b1; m16 = 2'b10;
    step();
    flush16 = 1'b0; v16 = 1'b0;
    for (int s = 0; s < 5; s++) begin
      total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL flush16[%0d] valid got=%b want=0", s, ov16); end
      step();
    end
    v16 = 1'b1; m16 = 2'b11; a16 = ea; b16 = eb;
    step();
    v16 = 1'b0;
    step(); step(); step();
    total++;
    if (ov16 !== 1'b1 || or16 !== ref_res(16, 2'b11, {16'b0, ea}, {16'b0, eb})) begin
      bad++;
      $display("FAIL flush16_after got v=%b r=%h want v=1 r=%h", ov16, or16, ref_res(16, 2'b11, {16'b0, ea}, {16'b0, eb}));
    end
    step();
  endtask

  task automatic test_reset_midflight();
    v32 = 1'b1; m32 = 2'b01; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
    v16 = 1'b1; m16 = 2'b01; a16 = 16'hFFFF; b16 = 16'hFFFF;
    step(); step(); step(); step();
    total++; if (ov32 !== 1'b1 || or32 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL pre_reset got v=%b r=%h want v=1 r=fffffffe", ov32, or32); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (ov32 !== 1'b0 || or32 !== 32'h0) begin bad++; $display("FAIL async_reset32 got v=%b r=%h want v=0 r=0", ov32, or32); end
    total++; if (ov16 !== 1'b0 || or16 !== 16'h0) begin bad++; $display("FAIL async_reset16 got v=%b r=%h want v=0 r=0", ov16, or16); end
    step();
    idle_inputs();
    reset_n = 1'b1;
    v32 = 1'b1; m32 = 2'b11; a32 = 32'h8000_0000; b32 = 32'h8000_0000;
    step();
    v32 = 1'b0;
    total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL post_reset_early valid got=%b want=0", ov32); end
    step();
    total++; if (ov32 !== 1'b1 || or32 !== 32'h4000_0000) begin bad++; $display("FAIL post_reset got v=%b r=%h want v=1 r=40000000", ov32, or32); end
    step();
  endtask

  // Random traffic on the 16-bit/LAT=4 instance: each accepted op is due LAT-1 enabled edges after its accept edge.
  task automatic test_random16();
    int          due_q [$];
    logic [15:0] res_q [$];
    logic [1:0]  mode_q [$];
    int          cnt;
    logic        ev;
    logic [15:0] er;
    logic [1:0]  em;
    logic        e, f, v;
    logic [1:0]  m;
    logic [15:0] a, b;
    cnt = 0; ev = 1'b0; er = '0; em = '0;
    for (int i = 0; i < 200; i++) begin
      if (i < 190) begin
        e = ($urandom_range(0, 9) < 7);
        f = ($urandom_range(0, 24) == 0);
        v = ($urandom_range(0, 9) < 8);
      end else begin
        e = 1'b1; f = 1'b0; v = 1'b0;
      end
      m = 2'($urandom);
      a = 16'(pick_operand());
      b = 16'(pick_operand());
      en16 = e; flush16 = f; v16 = v; m16 = m; a16 = a; b16 = b;
      step();
      if (e) cnt++;
      if (e && v && !f) begin
        due_q.push_back(cnt + 3);
        res_q.push_back(16'(ref_res(16, m, {16'b0, a}, {16'b0, b})));
        mode_q.push_back(m);
      end
      if (f) begin
        due_q.delete(); res_q.delete(); mode_q.delete();
        ev = 1'b0;
      end else if (e) begin
        if (due_q.size() > 0 && due_q[0] == cnt) begin
          ev = 1'b1;
          er = res_q.pop_front();
          em = mode_q.pop_front();
          void'(due_q.pop_front());
        end else begin
          ev = 1'b0;
        end
      end
      total++;
      if (ov16 !== ev || (ev && (or16 !== er || om16 !== em))) begin
        bad++;
        $display("FAIL rand16[%0d] got v=%b r=%h m=%b want v=%b r=%h m=%b", i, ov16, or16, om16, ev, er, em);
      end
    end
    total++;
    if (due_q.size() != 0) begin bad++; $display("FAIL rand16_drain pending=%0d want=0", due_q.size()); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_directed32();
    test_directed16();
    test_back_to_back_stall();
    test_flush32();
    test_flush16();
    test_reset_midflight();
    test_random16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
